// File: rtl/cycle_sequencer_pkg.sv
// Shared opcode and phase definitions for the VeriRISC sequencer.
//   opcode_t  : 3-bit instruction opcode as held in the IR
//   phase_t   : sequencer states; HALTED shares phase code 0 but sets bit 3
//   is_aluop(): opcodes that read an operand from memory into the ALU
package cycle_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_t;

  typedef enum logic [3:0] {
    PH_INST_ADDR  = 4'b0000,
    PH_INST_FETCH = 4'b0001,
    PH_INST_LOAD  = 4'b0010,
    PH_IDLE       = 4'b0011,
    PH_OP_ADDR    = 4'b0100,
    PH_OP_FETCH   = 4'b0101,
    PH_ALU_OP     = 4'b0110,
    PH_STORE      = 4'b0111,
    PH_HALTED     = 4'b1000
  } phase_t;

  function automatic logic is_aluop(opcode_t op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/cycle_sequencer.sv
// Eight-phase single-clock instruction sequencer with halt/resume,
// single-step gating and a retired-instruction counter.
// Ports:
//   clk, rst            : clock, async active-low reset
//   opcode, zero        : current IR opcode, accumulator-is-zero flag
//   step_mode/step      : pause before each fetch / release one instruction
//   resume              : leave HALTED
//   fetch               : PC drives memory address (phases 0-3)
//   mem_rd..load_pc     : datapath strobes, decoded from registered state
//   alu_en              : one-cycle ALU compute enable
//   halt, phase, retired: status / debug
module cycle_sequencer
  import cycle_sequencer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  opcode_t          opcode,
  input  logic             zero,
  input  logic             step_mode,
  input  logic             step,
  input  logic             resume,
  output logic             fetch,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             load_ir,
  output logic             load_ac,
  output logic             inc_pc,
  output logic             load_pc,
  output logic             alu_en,
  output logic             halt,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] retired
);

  phase_t           state_q, state_d;
  logic             halt_q, halt_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             aluop;

  assign aluop = is_aluop(opcode);

  // State, halt flag and retire counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= PH_INST_ADDR;
      halt_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      halt_q    <= halt_d;
      retired_q <= retired_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      PH_INST_ADDR:  if (!step_mode || step) state_d = PH_INST_FETCH;
      PH_INST_FETCH: state_d = PH_INST_LOAD;
      PH_INST_LOAD:  state_d = PH_IDLE;
      PH_IDLE:       state_d = PH_OP_ADDR;
      PH_OP_ADDR:    state_d = (opcode == OP_HLT) ? PH_HALTED : PH_OP_FETCH;
      PH_OP_FETCH:   state_d = PH_ALU_OP;
      PH_ALU_OP:     state_d = PH_STORE;
      PH_STORE:      state_d = PH_INST_ADDR;
      PH_HALTED:     if (resume) state_d = PH_INST_ADDR;
      default:       state_d = PH_INST_ADDR;
    endcase
  end

  // An instruction retires either on normal completion or when HLT parks us
  always_comb begin
    halt_d    = (state_d == PH_HALTED);
    retired_d = retired_q;
    if ((state_q == PH_STORE) ||
        (state_q == PH_OP_ADDR && opcode == OP_HLT))
      retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // Strobe decode from registered state only; step/resume never reach outputs
  always_comb begin
    fetch   = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    load_ir = 1'b0;
    load_ac = 1'b0;
    inc_pc  = 1'b0;
    load_pc = 1'b0;
    alu_en  = 1'b0;
    case (state_q)
      PH_INST_ADDR: begin
        fetch = 1'b1;
      end
      PH_INST_FETCH: begin
        fetch  = 1'b1;
        mem_rd = 1'b1;
      end
      PH_INST_LOAD, PH_IDLE: begin
        fetch   = 1'b1;
        mem_rd  = 1'b1;
        load_ir = 1'b1;
      end
      PH_OP_ADDR: begin
        inc_pc = 1'b1;
      end
      PH_OP_FETCH: begin
        mem_rd = aluop;
      end
      PH_ALU_OP: begin
        mem_rd  = aluop;
        alu_en  = 1'b1;
        inc_pc  = (opcode == OP_SKZ) && zero;
        load_pc = (opcode == OP_JMP);
      end
      PH_STORE: begin
        mem_rd  = aluop;
        load_ac = aluop;
        inc_pc  = (opcode == OP_JMP);
        load_pc = (opcode == OP_JMP);
        mem_wr  = (opcode == OP_STO);
      end
      default: ;
    endcase
  end

  assign halt    = halt_q;
  assign phase   = state_q[2:0];
  assign retired = retired_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
module tb_cycle_sequencer;
  import cycle_sequencer_pkg::*;

  logic    clk, rst, rst_w;
  opcode_t opcode;
  logic    zero, step_mode, step, resume;

  logic        fetch, mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, alu_en, halt;
  logic [2:0]  phase;
  logic [15:0] retired;

  logic        fetch_w, mem_rd_w, mem_wr_w, load_ir_w, load_ac_w, inc_pc_w, load_pc_w, alu_en_w, halt_w;
  logic [2:0]  phase_w;
  logic [3:0]  retired_w;

  int n_cmp = 0;
  int n_err = 0;
  int exp_ret = 0;

  cycle_sequencer #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .step_mode(step_mode), .step(step), .resume(resume),
    .fetch(fetch), .mem_rd(mem_rd), .mem_wr(mem_wr), .load_ir(load_ir),
    .load_ac(load_ac), .inc_pc(inc_pc), .load_pc(load_pc), .alu_en(alu_en),
    .halt(halt), .phase(phase), .retired(retired)
  );

  cycle_sequencer #(.CNT_W(4)) dut_w (
    .clk(clk), .rst(rst_w), .opcode(opcode), .zero(zero),
    .step_mode(step_mode), .step(step), .resume(resume),
    .fetch(fetch_w), .mem_rd(mem_rd_w), .mem_wr(mem_wr_w), .load_ir(load_ir_w),
    .load_ac(load_ac_w), .inc_pc(inc_pc_w), .load_pc(load_pc_w), .alu_en(alu_en_w),
    .halt(halt_w), .phase(phase_w), .retired(retired_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starting at phase 0: run one instruction and compare every phase's
  // outputs against per-phase bit masks (bit p = expected value in phase p).
  task automatic run_instr(input string nm, input opcode_t op, input logic z,
                           input logic [7:0] rd_m, input logic [7:0] ac_m,
                           input logic [7:0] inc_m, input logic [7:0] lpc_m,
                           input logic [7:0] wr_m);
    logic [7:0]  fe_m, ir_m, alu_m;
    logic [10:0] obs, exp;
    fe_m  = 8'b0000_1111;
    ir_m  = 8'b0000_1100;
    alu_m = 8'b0100_0000;
    opcode = op;
    zero   = z;
    for (int p = 0; p < 8; p++) begin
      obs = {phase, fetch, mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, alu_en};
      exp = {3'(p), fe_m[p], rd_m[p], wr_m[p], ir_m[p], ac_m[p], inc_m[p], lpc_m[p], alu_m[p]};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL %s_ph%0d: got %b want %b", nm, p, obs, exp);
      end
      tick();
    end
    exp_ret++;
    n_cmp++;
    if (phase !== 3'd0 || retired !== 16'(exp_ret)) begin
      n_err++;
      $display("FAIL %s_end: phase=%0d retired=%0d want 0/%0d", nm, phase, retired, exp_ret);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; rst_w = 1'b0;
    opcode = OP_LDA; zero = 1'b0; step_mode = 1'b0; step = 1'b0; resume = 1'b0;
    #3;
    n_cmp++;
    if ({phase, fetch, mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, alu_en, halt} !== 12'b000_1000_0000_0 ||
        retired !== 16'd0) begin
      n_err++;
      $display("FAIL reset_state: phase=%0d fetch=%b rd=%b halt=%b retired=%0d", phase, fetch, mem_rd, halt, retired);
    end
    tick(); tick();
    n_cmp++;
    if (phase !== 3'd0) begin
      n_err++;
      $display("FAIL reset_hold: phase=%0d want 0", phase);
    end
    rst = 1'b1;
  endtask

  task automatic test_lda();
    run_instr("lda", OP_LDA, 1'b0, 8'b1110_1110, 8'b1000_0000, 8'b0001_0000, 8'b0, 8'b0);
  endtask

  task automatic test_skz();
    run_instr("skz_z1", OP_SKZ, 1'b1, 8'b0000_1110, 8'b0, 8'b0101_0000, 8'b0, 8'b0);
    run_instr("skz_z0", OP_SKZ, 1'b0, 8'b0000_1110, 8'b0, 8'b0001_0000, 8'b0, 8'b0);
  endtask

  task automatic test_jmp_sto();
    run_instr("jmp", OP_JMP, 1'b0, 8'b0000_1110, 8'b0, 8'b1001_0000, 8'b1100_0000, 8'b0);
    run_instr("sto", OP_STO, 1'b1, 8'b0000_1110, 8'b0, 8'b0001_0000, 8'b0, 8'b1000_0000);
    run_instr("add", OP_ADD, 1'b1, 8'b1110_1110, 8'b1000_0000, 8'b0001_0000, 8'b0, 8'b0);
  endtask

  task automatic test_hlt();
    opcode = OP_HLT;
    for (int p = 0; p < 4; p++) tick();
    n_cmp++;
    if (phase !== 3'd4 || inc_pc !== 1'b1 || halt !== 1'b0) begin
      n_err++;
      $display("FAIL hlt_opaddr: phase=%0d inc_pc=%b halt=%b want 4/1/0", phase, inc_pc, halt);
    end
    tick();
    exp_ret++;
    for (int c = 0; c < 20; c++) begin
      n_cmp++;
      if ({mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, alu_en} !== 7'b0 ||
          halt !== 1'b1 || phase !== 3'd0) begin
        n_err++;
        $display("FAIL hlt_park%0d: strobes=%b halt=%b phase=%0d", c,
                 {mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, alu_en}, halt, phase);
      end
      step = (c == 10);
      tick();
      step = 1'b0;
    end
    n_cmp++;
    if (retired !== 16'(exp_ret) || halt !== 1'b1) begin
      n_err++;
      $display("FAIL hlt_retired: retired=%0d halt=%b want %0d/1", retired, halt, exp_ret);
    end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    opcode = OP_LDA;
    n_cmp++;
    if (phase !== 3'd0 || halt !== 1'b0) begin
      n_err++;
      $display("FAIL hlt_resume: phase=%0d halt=%b want 0/0", phase, halt);
    end
  endtask

  task automatic test_step();
    step_mode = 1'b1;
    opcode = OP_LDA;
    for (int c = 0; c < 10; c++) tick();
    n_cmp++;
    if (phase !== 3'd0 || retired !== 16'(exp_ret)) begin
      n_err++;
      $display("FAIL step_hold: phase=%0d retired=%0d want 0/%0d", phase, retired, exp_ret);
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    n_cmp++;
    if (phase !== 3'd1) begin
      n_err++;
      $display("FAIL step_release: phase=%0d want 1", phase);
    end
    tick(); tick();
    step = 1'b1;          // arrives in IDLE: must be dropped
    tick();
    step = 1'b0;
    n_cmp++;
    if (phase !== 3'd4) begin
      n_err++;
      $display("FAIL step_mid: phase=%0d want 4", phase);
    end
    for (int c = 0; c < 4; c++) tick();
    exp_ret++;
    n_cmp++;
    if (phase !== 3'd0 || retired !== 16'(exp_ret)) begin
      n_err++;
      $display("FAIL step_done: phase=%0d retired=%0d want 0/%0d", phase, retired, exp_ret);
    end
    for (int c = 0; c < 5; c++) tick();
    n_cmp++;
    if (phase !== 3'd0) begin
      n_err++;
      $display("FAIL step_noqueue: phase=%0d want 0", phase);
    end
    step_mode = 1'b0;
  endtask

  task automatic test_reset_mid();
    opcode = OP_LDA;
    for (int c = 0; c < 6; c++) tick();
    n_cmp++;
    if (phase !== 3'd6 || alu_en !== 1'b1 || mem_rd !== 1'b1) begin
      n_err++;
      $display("FAIL mid_aluop: phase=%0d alu_en=%b rd=%b want 6/1/1", phase, alu_en, mem_rd);
    end
    #2 rst = 1'b0;
    #1;
    exp_ret = 0;
    n_cmp++;
    if (phase !== 3'd0 || fetch !== 1'b1 || retired !== 16'd0 ||
        {mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, alu_en} !== 7'b0) begin
      n_err++;
      $display("FAIL mid_reset: phase=%0d fetch=%b retired=%0d strobes=%b", phase, fetch, retired,
               {mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, alu_en});
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (phase !== 3'd1) begin
      n_err++;
      $display("FAIL mid_release: phase=%0d want 1", phase);
    end
    for (int c = 0; c < 7; c++) tick();
  endtask

  task automatic test_wrap();
    opcode = OP_LDA;
    step_mode = 1'b0;
    rst_w = 1'b1;
    for (int c = 0; c < 15 * 8; c++) tick();
    n_cmp++;
    if (phase_w !== 3'd0 || retired_w !== 4'd15) begin
      n_err++;
      $display("FAIL wrap_15: phase=%0d retired=%0d want 0/15", phase_w, retired_w);
    end
    for (int c = 0; c < 8; c++) tick();
    n_cmp++;
    if (retired_w !== 4'd0) begin
      n_err++;
      $display("FAIL wrap_16: retired=%0d want 0", retired_w);
    end
  endtask

  initial begin
    test_reset();
    test_lda();
    test_skz();
    test_jmp_sto();
    test_hlt();
    test_step();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cycle_sequencer.md
# cycle_sequencer

Single-clock instruction sequencer for the VeriRISC CPU. It replaces the externally generated `fetch`, `control_clk` and `alu_clk` with an eight-phase state machine on one clock. Each cycle it decodes the current `opcode` and `zero` into the datapath strobes. It also adds halt/resume, single-step control and a retired-instruction counter. It sits between the instruction register/ALU and the accumulator, PC, IR and memory enables inside the CPU top level.

## Interface
Parameters:
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `opcode`  in  opcode_t (3)  current IR opcode.
- `zero`  in  1  ALU zero flag, accumulator == 0.
- `step_mode`  in  1  level; 1 means pause before each instruction fetch.
- `step`  in  1  one-cycle pulse; releases one instruction in step mode.
- `resume`  in  1  one-cycle pulse; leaves HALTED.
- `fetch`  out  1  mux select; 1 means PC drives the memory address.
- `mem_rd`, `mem_wr`, `load_ir`, `load_ac`, `inc_pc`, `load_pc`  out  1 each  datapath strobes.
- `alu_en`  out  1  one-cycle ALU compute enable.
- `halt`  out  1  CPU halted.
- `phase`  out  3  current phase encoding, for debug.
- `retired`  out  CNT_W  count of completed instructions.

## Operation
- Phase FSM, in order: INST_ADDR(0), INST_FETCH(1), INST_LOAD(2), IDLE(3), OP_ADDR(4), OP_FETCH(5), ALU_OP(6), STORE(7), plus HALTED(phase reads 0).
- ALUOP = opcode ∈ {ADD, AND, XOR, LDA}.
- `fetch` = 1 in phases 0–3 only.
- Strobes per phase; anything not listed is 0:
  - INST_FETCH: `mem_rd`.
  - INST_LOAD and IDLE: `mem_rd`, `load_ir`.
  - OP_ADDR: `inc_pc`.
  - OP_FETCH: `mem_rd`=ALUOP.
  - ALU_OP: `mem_rd`=ALUOP, `alu_en`=1, `inc_pc`=(SKZ & `zero`), `load_pc`=JMP.
  - STORE: `mem_rd`=ALUOP, `load_ac`=ALUOP, `inc_pc`=JMP, `load_pc`=JMP, `mem_wr`=STO.
- Transitions:
  - Each phase advances to the next every cycle, except as below.
  - INST_ADDR holds while `step_mode`=1 and `step`=0. With `step_mode`=0 it advances unconditionally.
  - OP_ADDR with opcode HLT goes to HALTED. `inc_pc` is still asserted in OP_ADDR, so PC points past HLT.
  - STORE goes to INST_ADDR.
  - HALTED holds until `resume`=1, then goes to INST_ADDR. `step` is ignored in HALTED.
- `halt` is registered: set on entry to HALTED, cleared on exit.
- `retired` increments by 1 on STORE→INST_ADDR and on OP_ADDR→HALTED. It wraps from 2^CNT_W−1 to 0.
- `step` pulses outside INST_ADDR are discarded. They are not queued.

## Timing
- Strobes and `fetch` are combinational decodes of the registered state plus `opcode`/`zero`. The datapath samples them on the next rising `clk`.
- There is no combinational path from `step`, `step_mode` or `resume` to any output.
- Free-run throughput: one instruction per 8 cycles. HLT takes 5 cycles (phases 0–4) before HALTED.
- Step mode: `step` sampled high in INST_ADDR gives INST_FETCH on the next cycle. The instruction completes 8 cycles after that sample, then the FSM waits again in INST_ADDR.
- `resume` sampled in HALTED: INST_ADDR and `halt`=0 on the next cycle.
- Reset (`rst`=0, asserted at any phase): immediately state=INST_ADDR, `halt`=0, `retired`=0, `phase`=0.
  - Outputs during reset: all strobes 0, `fetch`=1.
  - After release, first advance on the first rising `clk` with `rst`=1, subject to step gating.
- `opcode` must be stable from IDLE through STORE. It is decoded as-is in every phase; no internal latch.

## Structure
- Shared `opcodes` package: add `phase_t` (enum of the 9 states, HALTED encoded 3'b000 with a distinct 4th bit or separate enum value). Add an `ALUOP` membership function beside `opcode_t`.
- Single module. No sub-module is warranted; the retire counter is inline.
- The CPU top level instantiates `cycle_sequencer` in place of the current controller plus external phase clocks. `alu_en` gates the ALU register enable; the memory remains on the same edge discipline via strobes.

## Test plan
- Reset release with `step_mode`=0, `opcode`=LDA: `phase` steps 0→7→0. `mem_rd` is high in phases 1,2,3,5,6,7; `load_ac` is high only in phase 7. `retired`=1 after 8 cycles.
- `opcode`=SKZ, `zero`=1: `inc_pc` high in phases 4 and 6. With `zero`=0: `inc_pc` high in phase 4 only.
- `opcode`=JMP: `load_pc` high in phases 6 and 7; `inc_pc` high in phases 4 and 7. `opcode`=STO: `mem_wr` high only in phase 7 and `mem_rd` never high after phase 3.
- `opcode`=HLT: `halt`=1 from cycle 5 and `retired` increments once. All strobes stay 0 for 20 cycles. `resume` pulse gives `phase`=0 and `halt`=0 next cycle. A `step` pulse in HALTED has no effect.
- `step_mode`=1: FSM holds at phase 0 for 10 cycles. One `step` pulse gives exactly 8 further cycles, then holds again. A `step` during phase 3 is ignored.
- `rst` asserted mid-ALU_OP: `phase`=0, strobes 0, `retired`=0 with no clock edge. Set `CNT_W`=4 and run 16 instructions: `retired` wraps to 0.
